uart_cmd_host: RTL and testbench
================================

UART_CMD_HOST -- requirements
Module: uart_cmd_host

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 8, byte width.
- RF_ADDR, 4, register-file address width.
- TIMEOUT_CYCLES, 16'd4096, maximum idle CLK cycles while waiting on the UART.

REQ-002 Ports SHALL be as follows. Clock and reset:
- CLK  in  1  single clock; all state on rising edge.
- RST  in  1  asynchronous, active-low reset.

REQ-003 Command-side ports SHALL be:
- CMD_VLD  in  1  command request strobe.
- CMD_TYPE  in  2  0 RF_WR, 1 RF_RD, 2 ALU_OP, 3 ALU_NOP.
- CMD_ADDR  in  RF_ADDR  register address.
- CMD_DATA_A  in  DATA_WIDTH  write data / operand A.
- CMD_DATA_B  in  DATA_WIDTH  operand B.
- CMD_FUN  in  4  ALU function.
- CMD_BUSY  out  1  command in flight.

REQ-004 UART-side ports SHALL be:
- TX_DATA  out  DATA_WIDTH  byte to UART transmitter.
- TX_VLD  out  1  one-cycle byte strobe.
- TX_BUSY  in  1  transmitter busy, already synchronized to CLK.
- RX_DATA  in  DATA_WIDTH  byte from UART receiver.
- RX_VLD  in  1  one-cycle byte strobe, already synchronized.

REQ-005 Response ports SHALL be:
- RSP_DATA  out  2*DATA_WIDTH  response.
- RSP_VLD  out  1  one-cycle response-complete pulse.
- RSP_TIMEOUT  out  1  one-cycle timeout pulse.

Function
REQ-006 A command SHALL be accepted only in a cycle where CMD_VLD=1 and CMD_BUSY=0.
- All CMD_* fields are captured in that cycle.
- CMD_VLD while CMD_BUSY=1 is ignored.

REQ-007 CMD_BUSY SHALL be 1 from the cycle after acceptance through the RSP_VLD or RSP_TIMEOUT cycle inclusive, and 0 in the following cycle.

REQ-008 Transmitted frames SHALL be, in order:
- RF_WR: AA, {0,ADDR}, A.
- RF_RD: BB, {0,ADDR}.
- ALU_OP: CC, A, B, {4'h0,FUN}.
- ALU_NOP: DD, {4'h0,FUN}.

REQ-009 Expected response byte counts SHALL be: RF_WR 0, RF_RD 1, ALU_OP 2, ALU_NOP 2.

REQ-010 The FSM SHALL use states IDLE, SEND, WAIT_HI, WAIT_LO, RECV, DONE.
- IDLE -> SEND on acceptance.
- SEND -> WAIT_HI after the TX_VLD pulse.
- WAIT_HI -> WAIT_LO on TX_BUSY=1.
- WAIT_LO -> SEND if frame bytes remain; else -> RECV if a response is expected; else -> DONE.
- RECV -> DONE on the last expected byte.
- DONE -> IDLE.
- Any state -> IDLE on timeout.

REQ-011 In SEND, when TX_BUSY=0, the block SHALL drive TX_VLD=1 for exactly one cycle with the current byte on TX_DATA.
- TX_DATA holds that value until the next byte is issued.
- SEND with TX_BUSY=1 stalls without pulsing.

REQ-012 Latency: with TX_BUSY=0, the first TX_VLD SHALL occur one cycle after the acceptance cycle.

REQ-013 In RECV, the first RX_VLD byte SHALL be written to RSP_DATA[7:0] and the second to RSP_DATA[15:8] (LSB first).
- For RF_RD, RSP_DATA[15:8] = 8'h00.

REQ-014 RSP_VLD SHALL pulse in DONE, one cycle after the final RX_VLD (RF_RD, ALU_*) or after the last TX_BUSY fall (RF_WR).
- For RF_WR, RSP_DATA = 16'h0000.

REQ-015 RX_VLD outside RECV SHALL be discarded, with no state change.

REQ-016 RSP_DATA SHALL be cleared to 0 on acceptance and then hold its value until the next acceptance.

REQ-017 A 16-bit timeout counter SHALL clear on every state transition and on every RX_VLD in RECV, and increment otherwise in SEND, WAIT_HI, WAIT_LO and RECV.
- On reaching TIMEOUT_CYCLES-1, RSP_TIMEOUT pulses for one cycle and the FSM returns to IDLE.
- RSP_DATA retains any partially received bytes.
- RSP_VLD is not asserted.

REQ-018 RX_VLD coinciding with the timeout cycle SHALL be ignored; the timeout takes priority.

Reset
REQ-019 RST=0 SHALL immediately force the following, regardless of clock:
- FSM to IDLE.
- CMD_BUSY, TX_VLD, RSP_VLD, RSP_TIMEOUT = 0.
- TX_DATA, RSP_DATA, byte counters and timeout counter = 0.

REQ-020 Reset asserted mid-frame SHALL abandon the frame: no further TX_VLD and no response pulse after reset release.

REQ-021 After RST deasserts, the block SHALL accept a command at the first clock edge where CMD_VLD=1.

Verification
REQ-022 RF_WR, ADDR=4'h5, A=8'h3C, with a TX model busy 10 cycles per byte -> TX bytes AA,05,3C, each TX_VLD one cycle wide; RSP_VLD=1 with RSP_DATA=16'h0000; CMD_BUSY low the cycle after.

REQ-023 RF_RD, ADDR=4'h2; RX model returns 8'h7E -> TX bytes BB,02; RSP_DATA=16'h007E with RSP_VLD one cycle after RX_VLD.

REQ-024 ALU_OP, A=8'h0F, B=8'h10, FUN=4'h2; RX returns F0 then 00 -> TX bytes CC,0F,10,02; RSP_DATA=16'h00F0.

REQ-025 ALU_NOP, FUN=4'h1, TIMEOUT_CYCLES=64; RX sends only 8'h12 -> RSP_TIMEOUT pulses exactly 64 cycles after that byte; RSP_DATA=16'h0012; no RSP_VLD.

REQ-026 Second CMD_VLD while busy, plus a stray RX_VLD during SEND -> the second command is ignored, the stray byte is not captured, and the first command completes normally.

REQ-027 RST asserted after the second byte of ALU_OP -> all outputs zero immediately; after release, no TX_VLD occurs until a new CMD_VLD.

Source files
------------

// File: rtl/uart_cmd_host.sv
// -----------------------------------------------------------------------------
// uart_cmd_host
//
// Purpose:
//   Turns a single host command (register-file write/read or ALU request) into
//   a short byte frame for a UART transmitter, then collects the response bytes
//   from a UART receiver and reports them as one 16-bit response. A watchdog
//   counter abandons a command that stalls too long on the UART side.
//
// Ports:
//   CLK, RST        clock (rising edge) and asynchronous active-low reset
//   CMD_VLD         command request strobe, accepted only while CMD_BUSY=0
//   CMD_TYPE        0 RF_WR, 1 RF_RD, 2 ALU_OP, 3 ALU_NOP
//   CMD_ADDR        register address
//   CMD_DATA_A/B    write data / ALU operands
//   CMD_FUN         ALU function code
//   CMD_BUSY        command in flight
//   TX_DATA/TX_VLD  byte and one-cycle strobe towards the UART transmitter
//   TX_BUSY         transmitter busy (already synchronous to CLK)
//   RX_DATA/RX_VLD  byte and one-cycle strobe from the UART receiver
//   RSP_DATA        response, first received byte in the low half
//   RSP_VLD         one-cycle response-complete pulse
//   RSP_TIMEOUT     one-cycle timeout pulse
// -----------------------------------------------------------------------------
module uart_cmd_host #(
  parameter int          DATA_WIDTH     = 8,
  parameter int          RF_ADDR        = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_VLD,
  input  logic [1:0]              CMD_TYPE,
  input  logic [RF_ADDR-1:0]      CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_DATA_A,
  input  logic [DATA_WIDTH-1:0]   CMD_DATA_B,
  input  logic [3:0]              CMD_FUN,
  output logic                    CMD_BUSY,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VLD,
  input  logic                    TX_BUSY,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VLD,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_VLD,
  output logic                    RSP_TIMEOUT
);

  typedef enum logic [1:0] {
    OP_RF_WR   = 2'd0,
    OP_RF_RD   = 2'd1,
    OP_ALU_OP  = 2'd2,
    OP_ALU_NOP = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO,
    RECV,
    DONE
  } state_t;

  localparam logic [15:0] TMO_LAST = TIMEOUT_CYCLES - 16'd1;

  state_t                  state;
  op_t                     typ_q;
  logic [RF_ADDR-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [3:0]              fun_q;
  logic [1:0]              byte_idx;
  logic [1:0]              rx_cnt;
  logic [15:0]             tmo_cnt;
  logic                    counting;
  logic                    tmo_hit;

  // Byte number idx of the frame for a given command type. Byte 0 is the
  // type header; the rest carry the address, operands or function code.
  function automatic logic [DATA_WIDTH-1:0] frame_byte(
    input op_t                   typ,
    input logic [1:0]            idx,
    input logic [RF_ADDR-1:0]    addr,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [3:0]            fun
  );
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    case (typ)
      OP_RF_WR: begin
        case (idx)
          2'd0:    res = DATA_WIDTH'(8'hAA);
          2'd1:    res = DATA_WIDTH'(addr);
          default: res = a;
        endcase
      end
      OP_RF_RD: begin
        if (idx == 2'd0) res = DATA_WIDTH'(8'hBB);
        else             res = DATA_WIDTH'(addr);
      end
      OP_ALU_OP: begin
        case (idx)
          2'd0:    res = DATA_WIDTH'(8'hCC);
          2'd1:    res = a;
          2'd2:    res = b;
          default: res = DATA_WIDTH'(fun);
        endcase
      end
      OP_ALU_NOP: begin
        if (idx == 2'd0) res = DATA_WIDTH'(8'hDD);
        else             res = DATA_WIDTH'(fun);
      end
    endcase
    return res;
  endfunction

  // Index of the final frame byte for each command type.
  function automatic logic [1:0] frame_last(input op_t typ);
    logic [1:0] res;
    case (typ)
      OP_RF_WR:  res = 2'd2;
      OP_RF_RD:  res = 2'd1;
      OP_ALU_OP: res = 2'd3;
      default:   res = 2'd1;
    endcase
    return res;
  endfunction

  // Number of response bytes the far end returns for each command type.
  function automatic logic [1:0] rsp_count(input op_t typ);
    logic [1:0] res;
    case (typ)
      OP_RF_WR: res = 2'd0;
      OP_RF_RD: res = 2'd1;
      default:  res = 2'd2;
    endcase
    return res;
  endfunction

  // The watchdog only runs while waiting on the UART. Its terminal count marks
  // the timeout cycle itself, so RSP_TIMEOUT is decoded directly from state and
  // counter: the pulse lands in the last busy cycle and the FSM is back in IDLE
  // one cycle later. TX_VLD is decoded the same way so the first byte can go
  // out in the cycle right after acceptance; the timeout suppresses it.
  assign counting    = (state == SEND) || (state == WAIT_HI) ||
                       (state == WAIT_LO) || (state == RECV);
  assign tmo_hit     = counting && (tmo_cnt == TMO_LAST);
  assign RSP_TIMEOUT = tmo_hit;
  assign TX_VLD      = (state == SEND) && !TX_BUSY && !tmo_hit;

  // Command FSM: captures the command, walks the frame one byte per
  // transmitter handshake (wait for busy to rise, then to fall), gathers the
  // response bytes and flags completion. Every transition and every accepted
  // response byte restarts the watchdog; the timeout overrides everything.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      typ_q    <= OP_RF_WR;
      addr_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      fun_q    <= '0;
      byte_idx <= '0;
      rx_cnt   <= '0;
      tmo_cnt  <= '0;
      CMD_BUSY <= 1'b0;
      TX_DATA  <= '0;
      RSP_DATA <= '0;
      RSP_VLD  <= 1'b0;
    end else begin
      RSP_VLD <= 1'b0;
      if (tmo_hit) begin
        state    <= IDLE;
        tmo_cnt  <= '0;
        CMD_BUSY <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            tmo_cnt <= '0;
            if (CMD_VLD) begin
              typ_q    <= op_t'(CMD_TYPE);
              addr_q   <= CMD_ADDR;
              a_q      <= CMD_DATA_A;
              b_q      <= CMD_DATA_B;
              fun_q    <= CMD_FUN;
              byte_idx <= '0;
              rx_cnt   <= '0;
              RSP_DATA <= '0;
              CMD_BUSY <= 1'b1;
              TX_DATA  <= frame_byte(op_t'(CMD_TYPE), 2'd0, CMD_ADDR,
                                     CMD_DATA_A, CMD_DATA_B, CMD_FUN);
              state    <= SEND;
            end
          end

          SEND: begin
            if (!TX_BUSY) begin
              state   <= WAIT_HI;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end

          WAIT_HI: begin
            if (TX_BUSY) begin
              state   <= WAIT_LO;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end

          WAIT_LO: begin
            if (!TX_BUSY) begin
              tmo_cnt <= '0;
              if (byte_idx != frame_last(typ_q)) begin
                byte_idx <= 2'(byte_idx + 2'd1);
                TX_DATA  <= frame_byte(typ_q, 2'(byte_idx + 2'd1), addr_q,
                                       a_q, b_q, fun_q);
                state    <= SEND;
              end else if (rsp_count(typ_q) != 2'd0) begin
                state <= RECV;
              end else begin
                state   <= DONE;
                RSP_VLD <= 1'b1;
              end
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end

          RECV: begin
            if (RX_VLD) begin
              tmo_cnt <= '0;
              if (rx_cnt == 2'd0) RSP_DATA[DATA_WIDTH-1:0] <= RX_DATA;
              else                RSP_DATA[2*DATA_WIDTH-1:DATA_WIDTH] <= RX_DATA;
              rx_cnt <= 2'(rx_cnt + 2'd1);
              if (2'(rx_cnt + 2'd1) == rsp_count(typ_q)) begin
                state   <= DONE;
                RSP_VLD <= 1'b1;
              end
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end

          DONE: begin
            tmo_cnt  <= '0;
            CMD_BUSY <= 1'b0;
            state    <= IDLE;
          end

          default: begin
            tmo_cnt  <= '0;
            CMD_BUSY <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_host.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_host
//
// Purpose:
//   Directed self-checking bench for uart_cmd_host. A small transmitter model
//   records every byte and holds TX_BUSY for a programmable number of cycles;
//   response bytes are injected by the scenario tasks.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_uart_cmd_host;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_VLD = 1'b0;
  logic [1:0]  CMD_TYPE = 2'd0;
  logic [3:0]  CMD_ADDR = 4'd0;
  logic [7:0]  CMD_DATA_A = 8'd0;
  logic [7:0]  CMD_DATA_B = 8'd0;
  logic [3:0]  CMD_FUN = 4'd0;
  logic        CMD_BUSY;
  logic [7:0]  TX_DATA;
  logic        TX_VLD;
  logic        TX_BUSY = 1'b0;
  logic [7:0]  RX_DATA = 8'd0;
  logic        RX_VLD = 1'b0;
  logic [15:0] RSP_DATA;
  logic        RSP_VLD;
  logic        RSP_TIMEOUT;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          tx_busy_len = 10;
  int          busy_left = 0;
  int          wide_err = 0;
  int          rsp_pulses = 0;
  int          tmo_pulses = 0;
  logic        tx_prev_vld = 1'b0;
  logic [7:0]  tx_q[$];
  int          tx_cyc_q[$];

  uart_cmd_host #(
    .DATA_WIDTH(8),
    .RF_ADDR(4),
    .TIMEOUT_CYCLES(16'd64)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .CMD_VLD(CMD_VLD),
    .CMD_TYPE(CMD_TYPE),
    .CMD_ADDR(CMD_ADDR),
    .CMD_DATA_A(CMD_DATA_A),
    .CMD_DATA_B(CMD_DATA_B),
    .CMD_FUN(CMD_FUN),
    .CMD_BUSY(CMD_BUSY),
    .TX_DATA(TX_DATA),
    .TX_VLD(TX_VLD),
    .TX_BUSY(TX_BUSY),
    .RX_DATA(RX_DATA),
    .RX_VLD(RX_VLD),
    .RSP_DATA(RSP_DATA),
    .RSP_VLD(RSP_VLD),
    .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // Cycle number, stable across the falling edge where everything is sampled.
  always @(posedge CLK) cyc <= cyc + 1;

  // Transmitter model: logs each strobed byte and raises TX_BUSY from the
  // next cycle for tx_busy_len cycles. Also counts response/timeout pulses.
  always @(negedge CLK) begin
    if (TX_VLD) begin
      tx_q.push_back(TX_DATA);
      tx_cyc_q.push_back(cyc);
    end
    if (TX_VLD && tx_prev_vld) wide_err <= wide_err + 1;
    tx_prev_vld <= TX_VLD;
    if (RSP_VLD) rsp_pulses <= rsp_pulses + 1;
    if (RSP_TIMEOUT) tmo_pulses <= tmo_pulses + 1;
    TX_BUSY <= (busy_left > 0);
    if (TX_VLD) busy_left <= tx_busy_len;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end

  // Hard stop in case a scenario wedges despite its own bounds.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic issue_cmd(input logic [1:0] t, input logic [3:0] ad,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] f, output int acc);
    @(negedge CLK);
    CMD_TYPE = t; CMD_ADDR = ad; CMD_DATA_A = a; CMD_DATA_B = b; CMD_FUN = f;
    CMD_VLD = 1'b1;
    acc = cyc;
    @(negedge CLK);
    CMD_VLD = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, output int at);
    @(negedge CLK);
    RX_DATA = d; RX_VLD = 1'b1;
    at = cyc;
    @(negedge CLK);
    RX_VLD = 1'b0; RX_DATA = 8'h00;
  endtask

  task automatic wait_tx_count(input int n, input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge CLK);
      #1;
      if (tx_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_rsp(input int max_cyc, output logic gv, output logic gt,
                          output int at);
    gv = 1'b0; gt = 1'b0; at = -1;
    for (int i = 0; i < max_cyc && !(gv || gt); i++) begin
      @(negedge CLK);
      if (RSP_VLD || RSP_TIMEOUT) begin
        gv = RSP_VLD; gt = RSP_TIMEOUT; at = cyc;
      end
    end
  endtask

  task automatic clear_log();
    tx_q.delete();
    tx_cyc_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    tests++;
    if ({CMD_BUSY, TX_VLD, RSP_VLD, RSP_TIMEOUT} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b expected 0000",
               {CMD_BUSY, TX_VLD, RSP_VLD, RSP_TIMEOUT});
    end
    tests++;
    if (TX_DATA !== 8'h00 || RSP_DATA !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL reset_data: got tx=%h rsp=%h expected 00 0000", TX_DATA, RSP_DATA);
    end
    RST = 1'b1;
  endtask

  task automatic test_rf_rd();
    int acc, rxc, at; logic ok, gv, gt;
    tx_busy_len = 3;
    clear_log();
    issue_cmd(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, acc);
    wait_tx_count(2, 100, ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL rf_rd_tx_wait: got %0d bytes expected 2", tx_q.size()); end
    repeat (8) @(negedge CLK);
    send_rx(8'h7E, rxc);
    tests++;
    if (RSP_VLD !== 1'b1) begin
      fails++; $display("[TB] FAIL rf_rd_rsp_vld: got %b expected 1 one cycle after RX_VLD", RSP_VLD);
    end
    tests++;
    if (RSP_DATA !== 16'h007E) begin
      fails++; $display("[TB] FAIL rf_rd_rsp_data: got %h expected 007e", RSP_DATA);
    end
    tests++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'hBB || tx_q[1] !== 8'h02) begin
      fails++; $display("[TB] FAIL rf_rd_tx_bytes: got n=%0d %h %h expected 2 bb 02",
                        tx_q.size(), tx_q[0], tx_q[1]);
    end
    wait_rsp(3, gv, gt, at);
  endtask

  task automatic test_alu_op();
    int acc, rxc, at; logic ok, gv, gt;
    tx_busy_len = 3;
    clear_log();
    issue_cmd(2'd2, 4'h0, 8'h0F, 8'h10, 4'h2, acc);
    wait_tx_count(4, 200, ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL alu_op_tx_wait: got %0d bytes expected 4", tx_q.size()); end
    repeat (8) @(negedge CLK);
    send_rx(8'hF0, rxc);
    tests++;
    if (RSP_VLD !== 1'b0 || RSP_DATA !== 16'h00F0) begin
      fails++; $display("[TB] FAIL alu_op_partial: got vld=%b data=%h expected 0 00f0", RSP_VLD, RSP_DATA);
    end
    repeat (3) @(negedge CLK);
    send_rx(8'h00, rxc);
    tests++;
    if (RSP_VLD !== 1'b1 || RSP_DATA !== 16'h00F0) begin
      fails++; $display("[TB] FAIL alu_op_rsp: got vld=%b data=%h expected 1 00f0", RSP_VLD, RSP_DATA);
    end
    tests++;
    if (tx_q.size() != 4 || tx_q[0] !== 8'hCC || tx_q[1] !== 8'h0F ||
        tx_q[2] !== 8'h10 || tx_q[3] !== 8'h02) begin
      fails++; $display("[TB] FAIL alu_op_tx_bytes: got n=%0d %h %h %h %h expected 4 cc 0f 10 02",
                        tx_q.size(), tx_q[0], tx_q[1], tx_q[2], tx_q[3]);
    end
    wait_rsp(3, gv, gt, at);
  endtask

  task automatic test_rf_wr();
    int acc, at; logic gv, gt;
    tx_busy_len = 10;
    clear_log();
    issue_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, acc);
    wait_rsp(200, gv, gt, at);
    tests++;
    if (gv !== 1'b1 || gt !== 1'b0) begin
      fails++; $display("[TB] FAIL rf_wr_rsp: got vld=%b tmo=%b expected 1 0", gv, gt);
    end
    tests++;
    if (RSP_DATA !== 16'h0000) begin
      fails++; $display("[TB] FAIL rf_wr_rsp_data: got %h expected 0000", RSP_DATA);
    end
    tests++;
    if (CMD_BUSY !== 1'b1) begin
      fails++; $display("[TB] FAIL rf_wr_busy_at_rsp: got %b expected 1", CMD_BUSY);
    end
    tests++;
    if (tx_q.size() != 3 || tx_q[0] !== 8'hAA || tx_q[1] !== 8'h05 || tx_q[2] !== 8'h3C) begin
      fails++; $display("[TB] FAIL rf_wr_tx_bytes: got n=%0d %h %h %h expected 3 aa 05 3c",
                        tx_q.size(), tx_q[0], tx_q[1], tx_q[2]);
    end
    tests++;
    if (tx_cyc_q.size() < 1 || tx_cyc_q[0] != acc + 1) begin
      fails++; $display("[TB] FAIL rf_wr_latency: got cycle %0d expected %0d",
                        (tx_cyc_q.size() > 0) ? tx_cyc_q[0] : -1, acc + 1);
    end
    tests++;
    if (tx_cyc_q.size() < 3 || at != tx_cyc_q[2] + 12) begin
      fails++; $display("[TB] FAIL rf_wr_rsp_timing: got cycle %0d expected %0d",
                        at, (tx_cyc_q.size() > 2) ? tx_cyc_q[2] + 12 : -1);
    end
    tests++;
    if (wide_err != 0) begin
      fails++; $display("[TB] FAIL tx_vld_width: got %0d wide pulses expected 0", wide_err);
    end
    @(negedge CLK);
    tests++;
    if (CMD_BUSY !== 1'b0) begin
      fails++; $display("[TB] FAIL rf_wr_busy_after: got %b expected 0", CMD_BUSY);
    end
  endtask

  task automatic test_timeout();
    int acc, rxc, at, vld0; logic ok, gv, gt;
    tx_busy_len = 3;
    clear_log();
    issue_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h1, acc);
    wait_tx_count(2, 100, ok);
    tests++;
    if (!ok || tx_q[0] !== 8'hDD || tx_q[1] !== 8'h01) begin
      fails++; $display("[TB] FAIL nop_tx_bytes: got n=%0d %h %h expected 2 dd 01",
                        tx_q.size(), tx_q[0], tx_q[1]);
    end
    repeat (8) @(negedge CLK);
    vld0 = rsp_pulses;
    send_rx(8'h12, rxc);
    wait_rsp(100, gv, gt, at);
    tests++;
    if (gt !== 1'b1 || gv !== 1'b0 || at != rxc + 64) begin
      fails++; $display("[TB] FAIL nop_timeout: got tmo=%b vld=%b cycle=%0d expected 1 0 %0d",
                        gt, gv, at, rxc + 64);
    end
    tests++;
    if (RSP_DATA !== 16'h0012) begin
      fails++; $display("[TB] FAIL nop_timeout_data: got %h expected 0012", RSP_DATA);
    end
    @(negedge CLK);
    #1;
    tests++;
    if (CMD_BUSY !== 1'b0 || RSP_TIMEOUT !== 1'b0 || rsp_pulses != vld0) begin
      fails++; $display("[TB] FAIL nop_after_timeout: got busy=%b tmo=%b vld_pulses=%0d expected 0 0 %0d",
                        CMD_BUSY, RSP_TIMEOUT, rsp_pulses, vld0);
    end
  endtask

  task automatic test_back_to_back();
    int acc, rxc, at; logic ok, gv, gt;
    tx_busy_len = 3;
    clear_log();
    @(negedge CLK);
    CMD_TYPE = 2'd1; CMD_ADDR = 4'h9; CMD_VLD = 1'b1;
    acc = cyc;
    @(negedge CLK);
    tests++;
    if (CMD_BUSY !== 1'b1) begin
      fails++; $display("[TB] FAIL b2b_busy: got %b expected 1", CMD_BUSY);
    end
    CMD_TYPE = 2'd2; CMD_DATA_A = 8'h77; CMD_ADDR = 4'h3;
    RX_VLD = 1'b1; RX_DATA = 8'h55;
    @(negedge CLK);
    RX_VLD = 1'b0; RX_DATA = 8'h00;
    repeat (3) @(negedge CLK);
    CMD_VLD = 1'b0;
    wait_tx_count(2, 100, ok);
    repeat (8) @(negedge CLK);
    send_rx(8'hA5, rxc);
    tests++;
    if (RSP_VLD !== 1'b1 || RSP_DATA !== 16'h00A5) begin
      fails++; $display("[TB] FAIL b2b_rsp: got vld=%b data=%h expected 1 00a5", RSP_VLD, RSP_DATA);
    end
    repeat (20) @(negedge CLK);
    #1;
    tests++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'hBB || tx_q[1] !== 8'h09 || CMD_BUSY !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_second_ignored: got n=%0d %h %h busy=%b expected 2 bb 09 0",
                        tx_q.size(), tx_q[0], tx_q[1], CMD_BUSY);
    end
    wait_rsp(1, gv, gt, at);
  endtask

  task automatic test_reset_mid_frame();
    int acc, at, vld0, tmo0; logic ok, gv, gt;
    tx_busy_len = 10;
    clear_log();
    issue_cmd(2'd2, 4'h0, 8'h11, 8'h22, 4'h3, acc);
    wait_tx_count(2, 100, ok);
    #2;
    RST = 1'b0;
    #1;
    tests++;
    if ({CMD_BUSY, TX_VLD, RSP_VLD, RSP_TIMEOUT} !== 4'b0000 ||
        TX_DATA !== 8'h00 || RSP_DATA !== 16'h0000) begin
      fails++; $display("[TB] FAIL mid_reset_outputs: got flags=%b tx=%h rsp=%h expected 0000 00 0000",
                        {CMD_BUSY, TX_VLD, RSP_VLD, RSP_TIMEOUT}, TX_DATA, RSP_DATA);
    end
    vld0 = rsp_pulses; tmo0 = tmo_pulses;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (100) @(negedge CLK);
    #1;
    tests++;
    if (tx_q.size() != 2 || rsp_pulses != vld0 || tmo_pulses != tmo0) begin
      fails++; $display("[TB] FAIL mid_reset_quiet: got n=%0d vld=%0d tmo=%0d expected 2 %0d %0d",
                        tx_q.size(), rsp_pulses, tmo_pulses, vld0, tmo0);
    end
    tx_busy_len = 2;
    clear_log();
    issue_cmd(2'd0, 4'h1, 8'h5A, 8'h00, 4'h0, acc);
    wait_rsp(100, gv, gt, at);
    tests++;
    if (gv !== 1'b1 || tx_q.size() != 3 || tx_q[0] !== 8'hAA || tx_q[1] !== 8'h01 ||
        tx_q[2] !== 8'h5A || tx_cyc_q[0] != acc + 1) begin
      fails++; $display("[TB] FAIL post_reset_cmd: got vld=%b n=%0d %h %h %h first=%0d expected 1 3 aa 01 5a %0d",
                        gv, tx_q.size(), tx_q[0], tx_q[1], tx_q[2],
                        (tx_cyc_q.size() > 0) ? tx_cyc_q[0] : -1, acc + 1);
    end
  endtask

  // Scenario sequence; the summary line is the only unconditional output.
  initial begin
    test_reset();
    test_rf_rd();
    test_alu_op();
    test_rf_wr();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (5) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
